// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Multi-channel push-button conditioner for the vending machine front panel.
// Each channel synchronises its raw button input and rejects contact bounce.
// It then presents a clean debounced level and a single-clock press pulse to
// the vending FSM. Everything runs on the master clock. en_debounce (about
// 1 kHz) is only a sample strobe and is never used as a clock.
//
// Ports:
//   clk          master clock (100 MHz)
//   rst          asynchronous, active-high reset
//   en_debounce  one-clk sample strobe from the clock divider
//   btn_raw      asynchronous raw button inputs, active-high
//   btn_level    debounced level per channel
//   btn_pulse    one-clk press pulse per channel
//
// Optional build macro:
//   BTN_REPEAT_EN  a held button produces auto-repeat press pulses. The first
//                  repeat comes REPEAT_DELAY strobes after acceptance. Later
//                  repeats come every REPEAT_RATE strobes.
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int NUM_BTN        = 4,
    parameter int STABLE_SAMPLES = 20,
    parameter int CNT_W          = 5,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_debounce,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        ARM_HIGH  = 2'd1,
        HELD_HIGH = 2'd2,
        ARM_LOW   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

    // A parameter set outside the legal range would let the stability
    // counter wrap, so elaboration is refused.
    if (STABLE_SAMPLES < 2 || STABLE_SAMPLES > 31 || (2 ** CNT_W) <= STABLE_SAMPLES ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("button_debouncer: illegal parameter set");
    end

`ifdef BTN_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
`endif

    logic [NUM_BTN-1:0] sync_meta;
    logic [NUM_BTN-1:0] sync_s;

    // Two-flop synchroniser. It is clocked every cycle so that the sampled
    // value is settled by the time the next strobe arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= '0;
            sync_s    <= '0;
        end else begin
            sync_meta <= btn_raw;
            sync_s    <= sync_meta;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             pulse_q, pulse_d;
        logic             rpt_fire;

        // Channel state, stability counter and the registered outputs.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= IDLE_LOW;
                cnt_q   <= '0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                pulse_q <= pulse_d;
            end
        end

        // Bounce filter. A new level is accepted only after STABLE_SAMPLES
        // consecutive strobes agree with it. A disagreeing sample sends the
        // channel back to its settled state.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            if (en_debounce) begin
                case (state_q)
                    IDLE_LOW: begin
                        if (sync_s[g]) begin
                            state_d = ARM_HIGH;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                    ARM_HIGH: begin
                        if (!sync_s[g]) begin
                            state_d = IDLE_LOW;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = HELD_HIGH;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    HELD_HIGH: begin
                        if (!sync_s[g]) begin
                            state_d = ARM_LOW;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                    default: begin
                        if (sync_s[g]) begin
                            state_d = HELD_HIGH;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = IDLE_LOW;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                endcase
            end
            // The level is registered from the next state, so it changes on
            // the same edge as the state. A pulse marks its rising edge.
            level_d = (state_d == HELD_HIGH) || (state_d == ARM_LOW);
            pulse_d = (level_d && !level_q) || rpt_fire;
        end

`ifdef BTN_REPEAT_EN
        logic [RPT_W-1:0] rpt_q, rpt_d;
        logic             rpt_first_q, rpt_first_d;

        // Auto-repeat timer. It counts only strobes on which the channel stays
        // in HELD_HIGH, so a release glitch through ARM_LOW freezes it rather
        // than clearing it.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rpt_q       <= '0;
                rpt_first_q <= 1'b0;
            end else begin
                rpt_q       <= rpt_d;
                rpt_first_q <= rpt_first_d;
            end
        end

        always_comb begin
            rpt_d       = rpt_q;
            rpt_first_d = rpt_first_q;
            rpt_fire    = 1'b0;
            if (en_debounce) begin
                if (state_q == ARM_HIGH && state_d == HELD_HIGH) begin
                    rpt_d       = '0;
                    rpt_first_d = 1'b0;
                end else if (state_q == HELD_HIGH && state_d == HELD_HIGH) begin
                    if ((!rpt_first_q && rpt_q == RPT_W'(REPEAT_DELAY - 1)) ||
                        ( rpt_first_q && rpt_q == RPT_W'(REPEAT_RATE - 1))) begin
                        rpt_fire    = 1'b1;
                        rpt_d       = '0;
                        rpt_first_d = 1'b1;
                    end else begin
                        rpt_d = rpt_q + RPT_W'(1);
                    end
                end
            end
        end
`else
        assign rpt_fire = 1'b0;
`endif

        assign btn_level[g] = level_q;
        assign btn_pulse[g] = pulse_q;
    end

endmodule
